// File: rtl/synth_seq_pkg.sv
// Shared types and sizes for the step sequencer.
package synth_seq_pkg;

    localparam int unsigned NUM_STEPS = 16;
    localparam int unsigned NOTE_W    = 12;
    localparam int unsigned GATE_W    = 4;
    localparam int unsigned TICK_W    = 16;
    localparam int unsigned STEP_W    = 4;
    localparam int unsigned ENTRY_W   = NOTE_W + GATE_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_GATE = 2'd2,
        ST_REST = 2'd3
    } seq_state_e;

    // One step-table entry: gate length in ticks above the oscillator note.
    typedef struct packed {
        logic [GATE_W-1:0] gate;
        logic [NOTE_W-1:0] note;
    } step_entry_t;

endpackage

// File: rtl/seq_tick_gen.sv
// Free-running tick divider, held at zero while the sequencer is idle.
module seq_tick_gen
    import synth_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic [TICK_W-1:0] tick_div,
    output logic              tick_c
);

    logic [TICK_W-1:0] cnt;

    // A tick fires whenever the count has reached the (live) divider value.
    assign tick_c = en && (cnt >= tick_div);

    // Count up while enabled, reload to zero on each tick or when disabled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (!en || tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TICK_W'(1);
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// 16-step note sequencer: step table, play FSM and registered synth controls.
module note_sequencer
    import synth_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               stop,
    input  logic               loop,
    input  logic [TICK_W-1:0]  tick_div,
    input  logic [GATE_W-1:0]  step_ticks,
    input  logic [STEP_W-1:0]  last_step,
    input  logic               wr_en,
    input  logic [STEP_W-1:0]  wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    output logic [NOTE_W-1:0]  osc_count,
    output logic               trig,
    output logic               busy,
    output logic [STEP_W-1:0]  step,
    output logic               wrap
);

    localparam int unsigned GCMP_W = GATE_W + 1;

    seq_state_e        state, state_nxt;
    step_entry_t       table_q [NUM_STEPS];
    step_entry_t       rd_entry;
    logic [STEP_W-1:0] step_nxt;
    logic [GATE_W-1:0] tcnt, tcnt_nxt;
    logic [GATE_W-1:0] cur_gate, gate_nxt;
    logic [NOTE_W-1:0] osc_nxt;
    logic              wrap_nxt;
    logic              tick_c;

    seq_tick_gen u_tick (
        .clk      (clk),
        .rstn     (rstn),
        .en       (busy),
        .tick_div (tick_div),
        .tick_c   (tick_c)
    );

    // Step table; writable in any state, cleared by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(NUM_STEPS); i++) begin
                table_q[i] <= '0;
            end
        end else if (wr_en) begin
            table_q[wr_addr] <= step_entry_t'(wr_data);
        end
    end

    // Next-state logic; the table is sampled only on the edge entering LOAD.
    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        tcnt_nxt  = tcnt;
        gate_nxt  = cur_gate;
        osc_nxt   = osc_count;
        wrap_nxt  = 1'b0;
        rd_entry  = '0;

        if (stop) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt = ST_LOAD;
                        step_nxt  = '0;
                        tcnt_nxt  = '0;
                    end
                end
                ST_LOAD: begin
                    state_nxt = (cur_gate != '0) ? ST_GATE : ST_REST;
                    tcnt_nxt  = '0;
                end
                ST_GATE, ST_REST: begin
                    if (tick_c) begin
                        if (tcnt == step_ticks) begin
                            // Step end outranks gate end.
                            tcnt_nxt = '0;
                            if (step >= last_step) begin
                                if (loop) begin
                                    state_nxt = ST_LOAD;
                                    step_nxt  = '0;
                                    wrap_nxt  = 1'b1;
                                end else begin
                                    state_nxt = ST_IDLE;
                                end
                            end else begin
                                state_nxt = ST_LOAD;
                                step_nxt  = step + STEP_W'(1);
                            end
                        end else begin
                            tcnt_nxt = tcnt + GATE_W'(1);
                            if ((state == ST_GATE) &&
                                (GCMP_W'(tcnt) + GCMP_W'(1) == GCMP_W'(cur_gate))) begin
                                state_nxt = ST_REST;
                            end
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end

        if (state_nxt == ST_LOAD) begin
            // Forward a coincident write so the newest entry is played.
            rd_entry = (wr_en && (wr_addr == step_nxt)) ? step_entry_t'(wr_data)
                                                        : table_q[step_nxt];
            osc_nxt  = rd_entry.note;
            gate_nxt = rd_entry.gate;
        end
    end

    // State, counters and all outputs registered from next-state values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            step      <= '0;
            tcnt      <= '0;
            cur_gate  <= '0;
            osc_count <= '0;
            trig      <= 1'b0;
            busy      <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state     <= state_nxt;
            step      <= step_nxt;
            tcnt      <= tcnt_nxt;
            cur_gate  <= gate_nxt;
            osc_count <= osc_nxt;
            trig      <= (state_nxt == ST_GATE);
            busy      <= (state_nxt != ST_IDLE);
            wrap      <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with a timeline model of each play.
`timescale 1ns/1ps
module tb_note_sequencer;

    localparam int MAXC = 64;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start, stop, loop;
    logic [15:0] tick_div;
    logic [3:0]  step_ticks, last_step;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [11:0] osc_count;
    logic        trig, busy, wrap;
    logic [3:0]  step;

    int checks = 0;
    int failures = 0;

    logic [15:0] m_tab [16];
    logic [11:0] m_osc;
    logic [3:0]  m_step;

    logic        e_trig [MAXC];
    logic        e_busy [MAXC];
    logic        e_wrap [MAXC];
    logic [11:0] e_osc  [MAXC];
    logic [3:0]  e_step [MAXC];
    logic        c_trig [MAXC];
    logic        c_busy [MAXC];
    logic        c_wrap [MAXC];
    logic [11:0] c_osc  [MAXC];
    logic [3:0]  c_step [MAXC];

    int cur_cyc = 0;
    bit chk_en = 1'b0;

    note_sequencer dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .stop       (stop),
        .loop       (loop),
        .tick_div   (tick_div),
        .step_ticks (step_ticks),
        .last_step  (last_step),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .osc_count  (osc_count),
        .trig       (trig),
        .busy       (busy),
        .step       (step),
        .wrap       (wrap)
    );

    // ~20.48 MHz
    always #24.414 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Compare process: every scenario cycle, on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            c_trig[cur_cyc] = trig;
            c_busy[cur_cyc] = busy;
            c_wrap[cur_cyc] = wrap;
            c_osc[cur_cyc]  = osc_count;
            c_step[cur_cyc] = step;
            check($sformatf("trig@%0d", cur_cyc), 32'(trig),      32'(e_trig[cur_cyc]));
            check($sformatf("busy@%0d", cur_cyc), 32'(busy),      32'(e_busy[cur_cyc]));
            check($sformatf("wrap@%0d", cur_cyc), 32'(wrap),      32'(e_wrap[cur_cyc]));
            check($sformatf("osc@%0d",  cur_cyc), 32'(osc_count), 32'(e_osc[cur_cyc]));
            check($sformatf("step@%0d", cur_cyc), 32'(step),      32'(e_step[cur_cyc]));
        end
    end

    // Cycle offset from LOAD of the j-th tick that counts within a step.
    function automatic int tick_off(input int j, input int d);
        return (d == 0) ? j : (j - 1) * (d + 1) + d;
    endfunction

    task automatic put(input int c, input logic b, input logic t, input logic w,
                       input logic [11:0] o, input logic [3:0] s);
        e_busy[c] = b; e_trig[c] = t; e_wrap[c] = w; e_osc[c] = o; e_step[c] = s;
    endtask

    // Expected timeline: each step is a LOAD cycle then GATE/REST until the
    // (step_ticks+1)-th counted tick; trig is high up to the gate-th tick.
    task automatic build(input int n, input int st_c, input int sp_c, input int w_c,
                         input logic [3:0] w_a, input logic [15:0] w_d);
        int c, s, len, g, gend, d, t;
        logic [11:0] h_osc;
        logic [3:0]  h_step;
        logic [15:0] ent;
        logic        wf, playing;
        d = int'(tick_div);
        t = int'(step_ticks);
        h_osc = m_osc;
        h_step = m_step;
        s = 0;
        wf = 1'b0;
        playing = (st_c != sp_c);
        c = 0;
        while (c < n) begin
            if (!playing || c <= st_c || c > sp_c) begin
                put(c, 1'b0, 1'b0, 1'b0, h_osc, h_step);
                c++;
            end else begin
                ent = (w_c >= 0 && w_c < c && int'(w_a) == s) ? w_d : m_tab[s];
                len = tick_off(t + 1, d) + 1;
                g = int'(ent[15:12]);
                gend = (g == 0) ? 0 : ((tick_off(g, d) < len - 1) ? tick_off(g, d) : len - 1);
                h_osc = ent[11:0];
                h_step = 4'(s);
                for (int off = 0; off < len && c < n && c <= sp_c; off++) begin
                    put(c, 1'b1, (off >= 1 && off <= gend), (off == 0 && wf), h_osc, h_step);
                    c++;
                end
                if (s >= int'(last_step)) begin
                    if (loop) begin s = 0; wf = 1'b1; end
                    else playing = 1'b0;
                end else begin
                    s++;
                    wf = 1'b0;
                end
            end
        end
    endtask

    // Drive one scenario; entered and left just after a rising edge.
    task automatic run_scn(input int n, input int st_c, input int sp_c, input int w_c,
                           input logic [3:0] w_a, input logic [15:0] w_d);
        build(n, st_c, sp_c, w_c, w_a, w_d);
        for (int c = 0; c < n; c++) begin
            cur_cyc = c;
            start   = (c == st_c);
            stop    = (c == sp_c);
            wr_en   = (c == w_c);
            wr_addr = w_a;
            wr_data = w_d;
            chk_en  = 1'b1;
            @(posedge clk);
            #1;
        end
        chk_en = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        wr_en = 1'b0;
        if (w_c >= 0) m_tab[w_a] = w_d;
        m_osc = e_osc[n-1];
        m_step = e_step[n-1];
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        m_tab[a] = d;
    endtask

    task automatic cfg(input logic [15:0] d, input logic [3:0] t, input logic [3:0] l, input logic lp);
        tick_div = d; step_ticks = t; last_step = l; loop = lp;
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
        tick_div = '0; step_ticks = '0; last_step = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        for (int i = 0; i < 16; i++) m_tab[i] = '0;
        m_osc = '0;
        m_step = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_trig", 32'(trig), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_osc",  32'(osc_count), 32'd0);
        check("rst_step", 32'(step), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk);
        #1;

        // Basic two-step play, no loop.
        wr(4'd0, 16'h1100);
        wr(4'd1, 16'h0200);
        cfg(16'd3, 4'd1, 4'd1, 1'b0);
        run_scn(20, 0, 1000, -1, 4'd0, 16'h0);
        check("A_osc1",   32'(c_osc[1]),  32'h100);
        check("A_trig1",  32'(c_trig[1]), 32'd0);
        check("A_trig2",  32'(c_trig[2]), 32'd1);
        check("A_trig4",  32'(c_trig[4]), 32'd1);
        check("A_trig5",  32'(c_trig[5]), 32'd0);
        check("A_osc9",   32'(c_osc[9]),  32'h200);
        check("A_step9",  32'(c_step[9]), 32'd1);
        check("A_busy16", 32'(c_busy[16]), 32'd1);
        check("A_busy17", 32'(c_busy[17]), 32'd0);

        // Same play with loop, stopped after the wrap.
        cfg(16'd3, 4'd1, 4'd1, 1'b1);
        run_scn(23, 0, 20, -1, 4'd0, 16'h0);
        check("B_wrap1",  32'(c_wrap[1]),  32'd0);
        check("B_wrap16", 32'(c_wrap[16]), 32'd0);
        check("B_wrap17", 32'(c_wrap[17]), 32'd1);
        check("B_wrap18", 32'(c_wrap[18]), 32'd0);
        check("B_step17", 32'(c_step[17]), 32'd0);
        check("B_osc17",  32'(c_osc[17]),  32'h100);
        check("B_trig18", 32'(c_trig[18]), 32'd1);
        check("B_busy21", 32'(c_busy[21]), 32'd0);

        // Long gates, one tick per step: trig drops only in LOAD.
        wr(4'd0, 16'hF111);
        wr(4'd1, 16'hF222);
        wr(4'd2, 16'hF333);
        cfg(16'd0, 4'd0, 4'd2, 1'b0);
        run_scn(9, 0, 1000, -1, 4'd0, 16'h0);
        check("C_trig2", 32'(c_trig[2]), 32'd1);
        check("C_trig3", 32'(c_trig[3]), 32'd0);
        check("C_trig4", 32'(c_trig[4]), 32'd1);
        check("C_trig5", 32'(c_trig[5]), 32'd0);
        check("C_trig6", 32'(c_trig[6]), 32'd1);
        check("C_osc5",  32'(c_osc[5]),  32'h333);
        check("C_busy7", 32'(c_busy[7]), 32'd0);

        // Stop while gating.
        wr(4'd0, 16'h1100);
        wr(4'd1, 16'h0200);
        cfg(16'd3, 4'd1, 4'd1, 1'b0);
        run_scn(6, 0, 3, -1, 4'd0, 16'h0);
        check("D_trig3", 32'(c_trig[3]), 32'd1);
        check("D_trig4", 32'(c_trig[4]), 32'd0);
        check("D_busy4", 32'(c_busy[4]), 32'd0);
        check("D_osc4",  32'(c_osc[4]),  32'h100);

        // Start and stop together: stop wins.
        run_scn(4, 0, 0, -1, 4'd0, 16'h0);
        check("E_busy1", 32'(c_busy[1]), 32'd0);
        check("E_trig1", 32'(c_trig[1]), 32'd0);

        // Rewrite the playing step; new note appears at its next LOAD.
        cfg(16'd3, 4'd1, 4'd1, 1'b1);
        run_scn(35, 0, 33, 12, 4'd1, 16'h3ABC);
        check("G_osc16",  32'(c_osc[16]),  32'h200);
        check("G_osc25",  32'(c_osc[25]),  32'hABC);
        check("G_trig32", 32'(c_trig[32]), 32'd1);
        check("G_trig33", 32'(c_trig[33]), 32'd0);

        // Four steps with mixed gates, tick_div=1, step_ticks=2.
        wr(4'd0, 16'h2123);
        wr(4'd1, 16'h0456);
        wr(4'd2, 16'h5789);
        wr(4'd3, 16'h1FFF);
        cfg(16'd1, 4'd2, 4'd3, 1'b0);
        run_scn(28, 0, 1000, -1, 4'd0, 16'h0);
        check("H_trig4",  32'(c_trig[4]),  32'd1);
        check("H_trig5",  32'(c_trig[5]),  32'd0);
        check("H_trig8",  32'(c_trig[8]),  32'd0);
        check("H_trig18", 32'(c_trig[18]), 32'd1);
        check("H_trig20", 32'(c_trig[20]), 32'd1);
        check("H_trig21", 32'(c_trig[21]), 32'd0);
        check("H_osc19",  32'(c_osc[19]),  32'hFFF);
        check("H_busy25", 32'(c_busy[25]), 32'd0);

        // Reset in the middle of a gate.
        cfg(16'd3, 4'd1, 4'd1, 1'b0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("F_pre_trig", 32'(trig), 32'd1);
        #5;
        rstn = 1'b0;
        #1;
        check("F_async_trig", 32'(trig), 32'd0);
        check("F_async_busy", 32'(busy), 32'd0);
        check("F_async_osc",  32'(osc_count), 32'd0);
        check("F_async_step", 32'(step), 32'd0);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) m_tab[i] = '0;
        m_osc = '0;
        m_step = '0;
        cfg(16'd0, 4'd0, 4'd15, 1'b0);
        run_scn(38, 3, 1000, -1, 4'd0, 16'h0);
        check("F_busy2",  32'(c_busy[2]),  32'd0);
        check("F_busy20", 32'(c_busy[20]), 32'd1);
        check("F_osc20",  32'(c_osc[20]),  32'd0);
        check("F_trig21", 32'(c_trig[21]), 32'd0);
        check("F_step34", 32'(c_step[34]), 32'd15);
        check("F_busy37", 32'(c_busy[37]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
